// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_bank_arbiter
// Description : Round-robin arbiter sharing one LED bank among N_REQ
//               requesters. A new grant is protected from preemption by
//               another requester for HOLD_CYCLES edges, which means a grant
//               under contention stays visible for HOLD_CYCLES+1 cycles.
//               While nobody owns the bank, IDLE_PATTERN is driven.
//               Optional feature macro: LED_ARB_PRIORITY_EN. When it is
//               defined, requester 0 is an urgent override that preempts
//               any other owner and is never preempted itself.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               req    - per-requester level request  [N_REQ]
//               data   - packed requester patterns    [N_REQ*LED_W]
//               grant  - registered one-hot grant or zero
//               led    - registered LED bank drive
//               busy   - registered, high while a grant is active
//               owner  - registered index of current/most recent grantee
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank_arbiter #(
    parameter int               N_REQ        = 4,
    parameter int               LED_W        = 8,
    parameter int               HOLD_CYCLES  = 16,
    parameter logic [LED_W-1:0] IDLE_PATTERN = {LED_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*LED_W-1:0]    data,
    output logic [N_REQ-1:0]          grant,
    output logic [LED_W-1:0]          led,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    // The counter is loaded with HOLD_CYCLES on every new grant so the
    // protected tenure is HOLD_CYCLES+1 displayed cycles.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [OW-1:0]       owner_n;
    logic                busy_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [LED_W-1:0]    led_n;
    logic [N_REQ-1:0]    grant_n;

    logic [OW-1:0]       pick;
    logic                others;
    logic                can_rotate;
    logic [LED_W-1:0]    pick_data;
    logic [LED_W-1:0]    owner_data;

    // Round-robin pick: scan offsets from N_REQ down to 1 so the smallest
    // offset from owner+1 overwrites last and wins; the owner itself
    // (offset N_REQ) is therefore considered last.
    always_comb begin
        pick   = owner;
        others = |(req & ~(N_REQ'(1) << owner));
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(owner) + k) % N_REQ]) begin
                pick = OW'((int'(owner) + k) % N_REQ);
            end
        end
`ifdef LED_ARB_PRIORITY_EN
        if (req[0]) begin
            pick = '0;
        end
`endif
    end

`ifdef LED_ARB_PRIORITY_EN
    // Requester 0 is never rotated away from once it owns the bank.
    assign can_rotate = others && (owner != '0);
`else
    assign can_rotate = others;
`endif

    assign pick_data  = data[int'(pick)  * LED_W +: LED_W];
    assign owner_data = data[int'(owner) * LED_W +: LED_W];

    always_comb begin
        logic take;
        take    = 1'b0;
        state_n = state;
        owner_n = owner;
        busy_n  = busy;
        cnt_n   = cnt;
        led_n   = led;

        case (state)
            ST_IDLE: begin
                led_n = IDLE_PATTERN;
                if (|req) begin
                    take = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef LED_ARB_PRIORITY_EN
                if (req[0] && (owner != '0)) begin
                    take = 1'b1;
                end else
`endif
                if (!req[owner]) begin
                    // Owner released: hand off directly or fall back to idle.
                    if (others) begin
                        take = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        led_n   = IDLE_PATTERN;
                        cnt_n   = '0;
                    end
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                    led_n = owner_data;
                end else if (can_rotate) begin
                    take = 1'b1;
                end else begin
                    // Sole requester after expiry keeps the bank, counter parks at 0.
                    led_n = owner_data;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                led_n   = IDLE_PATTERN;
            end
        endcase

        if (take) begin
            state_n = ST_HOLD;
            owner_n = pick;
            busy_n  = 1'b1;
            cnt_n   = HOLD_LOAD;
            led_n   = pick_data;
        end
    end

    assign grant_n = busy_n ? (N_REQ'(1) << owner_n) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            led   <= IDLE_PATTERN;
            owner <= OW'(N_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            busy  <= busy_n;
            led   <= led_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    end

endmodule
`default_nettype wire
